spi_frame_slave: RTL and testbench

SPI mode-0 slave framing stage that sits directly downstream of `synchronization`. It takes the synchronized `sck_r`/`sck_f`/`cs_r`/`cs_f`/`cs_sync` strobes plus raw MOSI and assembles MSB-first bytes. It decodes a command/address byte followed by data bytes, and issues single-cycle register writes to the neuron's weight/input register file, with auto-incrementing addresses. Optionally it shifts register contents back out on MISO.

---
 rtl/spi_frame_slave.sv | 149 ++++++++++++++
 tb/tb_spi_frame_slave.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_slave.sv
// SPI mode-0 slave framing: assembles MSB-first bytes from synchronized SCK/CS strobes,
// decodes a command/address byte and issues auto-incrementing register writes.
// Define SPI_FRAME_READBACK_EN to enable register readback on MISO.
module spi_frame_slave #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck_r,
    input  logic              sck_f,
    input  logic              cs_r,
    input  logic              cs_f,
    input  logic              cs_sync,
    input  logic              mosi,
    output logic              miso,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              mosi_m;
    logic              mosi_s;
    logic [2:0]        bit_cnt;
    logic [7:0]        rx_sr;
    logic [ADDR_W-1:0] addr;
    logic              rw;

    logic              active;
    logic              sck_rise;
    logic              sck_fall;
    logic              byte_done;
    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] addr_inc;

    // CS edges take priority over any SCK strobe arriving in the same cycle.
    assign active    = (state != IDLE) && !cs_sync && !cs_r && !cs_f;
    assign sck_rise  = active && sck_r;
    assign sck_fall  = active && sck_f;
    assign byte_done = sck_rise && (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sr[6:0], mosi_s};
    assign addr_inc  = addr + ADDR_W'(1);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_m <= 1'b0;
            mosi_s <= 1'b0;
        end else begin
            mosi_m <= mosi;
            mosi_s <= mosi_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (cs_r)                             state_nx = IDLE;
        else if (cs_f)                        state_nx = ADDR;
        else if (state == ADDR && byte_done)  state_nx = DATA;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= 3'd0;
            rx_sr   <= 8'd0;
            addr    <= '0;
            rw      <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'd0;
        end else begin
            wr_en <= 1'b0;
            if (cs_f && !cs_r) begin
                bit_cnt <= 3'd0;
                rx_sr   <= 8'd0;
            end else if (sck_rise) begin
                rx_sr   <= rx_byte;
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_done) begin
                    if (state == ADDR) begin
                        rw   <= rx_byte[7];
                        addr <= rx_byte[ADDR_W-1:0];
                    end else begin
                        addr <= addr_inc;
                        if (!rw) begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr;
                            wr_data <= rx_byte;
                        end
                    end
                end
            end
        end
    end

`ifdef SPI_FRAME_READBACK_EN
    logic [7:0] tx_sr;

    // The byte for the next read slot is loaded on the first falling edge of that slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sr   <= 8'd0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else begin
            rd_en <= 1'b0;
            if (cs_f && !cs_r) begin
                tx_sr <= 8'd0;
            end else if (sck_fall) begin
                if (state == DATA && rw && bit_cnt == 3'd0) begin
                    tx_sr <= rd_data;
                    rd_en <= 1'b1;
                end else begin
                    tx_sr <= {tx_sr[6:0], 1'b0};
                end
            end
            if (byte_done) begin
                if (state == ADDR)  rd_addr <= rx_byte[ADDR_W-1:0];
                else if (rw)        rd_addr <= addr_inc;
            end
        end
    end

    assign miso = tx_sr[7];
`else
    logic unused_rd;
    assign unused_rd = ^{rd_data, sck_fall};
    assign miso      = 1'b0;
    assign rd_en     = 1'b0;
    assign rd_addr   = '0;
`endif

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: table of write frames plus hand-written
// sequences for reset mid-frame, partial bytes and readback.
module tb_spi_frame_slave;

    logic       clk = 1'b0;
    logic       rst;
    logic       sck_r, sck_f, cs_r, cs_f, cs_sync, mosi;
    logic       miso, wr_en, rd_en, busy;
    logic [6:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;

    int n_checks = 0;
    int n_pass   = 0;
    int rd_en_cnt = 0;
    logic fall_pending = 1'b0;
    logic [14:0] exp_q[$];
    logic [14:0] exp_e;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [6:0] ea0;
        logic [6:0] ea1;
    } wvec_t;

    wvec_t vecs[4];

    spi_frame_slave #(.ADDR_W(7)) dut (
        .clk(clk), .rst(rst), .sck_r(sck_r), .sck_f(sck_f), .cs_r(cs_r), .cs_f(cs_f),
        .cs_sync(cs_sync), .mosi(mosi), .miso(miso), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
    );

    // Register file model: contents are address + 0x40.
    assign rd_data = {1'b0, rd_addr} + 8'h40;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Write scoreboard: every wr_en must match the queue head and coincide with the
    // cycle right after the completing sck_r pulse.
    always @(posedge clk) begin
        #1;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(wr_en), 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("wr_addr_data", 32'({wr_addr, wr_data}), 32'(exp_e));
                check("wr_latency", 32'(sck_r), 32'd1);
            end
        end
        if (rd_en === 1'b1) rd_en_cnt++;
    end

    task automatic start_frame();
        @(negedge clk);
        fall_pending = 1'b0;
        check("busy_before_csf", 32'(busy), 32'd0);
        cs_sync = 1'b0;
        cs_f = 1'b1;
        @(negedge clk);
        cs_f = 1'b0;
        check("busy_after_csf", 32'(busy), 32'd1);
    endtask

    task automatic end_frame(input logic chk_busy);
        @(negedge clk);
        cs_r = 1'b1;
        cs_sync = 1'b1;
        if (chk_busy) check("busy_at_csr", 32'(busy), 32'd1);
        @(negedge clk);
        cs_r = 1'b0;
        check("busy_after_csr", 32'(busy), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    // One SCK period: falling edge of the previous bit (if any), low phase, rising edge, high phase.
    task automatic send_bit(input logic b, output logic m);
        if (fall_pending) begin
            sck_f = 1'b1;
            @(negedge clk);
            sck_f = 1'b0;
        end
        mosi = b;
        repeat (4) @(negedge clk);
        m = miso;
        sck_r = 1'b1;
        @(negedge clk);
        sck_r = 1'b0;
        repeat (3) @(negedge clk);
        fall_pending = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] mb);
        logic m;
        mb = 8'd0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], m);
            mb = {mb[6:0], m};
        end
    endtask

    initial begin
        logic [7:0] mb0, mb1, mb2;
        logic       m;
        rst = 1'b1; sck_r = 1'b0; sck_f = 1'b0; cs_r = 1'b0; cs_f = 1'b0;
        cs_sync = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso",    32'(miso),    32'd0);
        check("rst_wr_en",   32'(wr_en),   32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_rd_en",   32'(rd_en),   32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        vecs[0] = '{cmd: 8'h05, d0: 8'hA5, d1: 8'h3C, ea0: 7'h05, ea1: 7'h06};
        vecs[1] = '{cmd: 8'h7F, d0: 8'h11, d1: 8'h22, ea0: 7'h7F, ea1: 7'h00};
        vecs[2] = '{cmd: 8'h40, d0: 8'h00, d1: 8'hFF, ea0: 7'h40, ea1: 7'h41};
        vecs[3] = '{cmd: 8'h00, d0: 8'h5A, d1: 8'hC3, ea0: 7'h00, ea1: 7'h01};

        for (int v = 0; v < 4; v++) begin
            exp_q.push_back({vecs[v].ea0, vecs[v].d0});
            exp_q.push_back({vecs[v].ea1, vecs[v].d1});
            start_frame();
            send_byte(vecs[v].cmd, mb0);
            send_byte(vecs[v].d0, mb1);
            send_byte(vecs[v].d1, mb2);
            end_frame(1'b1);
            check("wr_count", 32'(exp_q.size()), 32'd0);
            check("wr_addr_hold", 32'(wr_addr), 32'(vecs[v].ea1));
            check("wr_data_hold", 32'(wr_data), 32'(vecs[v].d1));
            exp_q.delete();
        end

        // Reset mid-byte in ADDR, then SCK activity with CS still low must not write.
        start_frame();
        for (int i = 0; i < 3; i++) send_bit(1'b0, m);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_wr_en",   32'(wr_en),   32'd0);
        check("midrst_wr_addr", 32'(wr_addr), 32'd0);
        check("midrst_wr_data", 32'(wr_data), 32'd0);
        check("midrst_rd_addr", 32'(rd_addr), 32'd0);
        check("midrst_miso",    32'(miso),    32'd0);
        check("midrst_busy",    32'(busy),    32'd0);
        send_byte(8'h05, mb0);
        send_byte(8'hA5, mb0);
        send_byte(8'h3C, mb0);
        check("midrst_busy_after_sck", 32'(busy), 32'd0);
        end_frame(1'b0);

        // Partial byte at frame end is discarded.
        exp_q.push_back({7'h10, 8'hFF});
        start_frame();
        send_byte(8'h10, mb0);
        send_byte(8'hFF, mb0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, m);
        end_frame(1'b1);
        check("partial_wr_count", 32'(exp_q.size()), 32'd0);
        check("partial_wr_addr",  32'(wr_addr), 32'h10);
        check("partial_wr_data",  32'(wr_data), 32'hFF);
        exp_q.delete();

        // Read frame from address 0x02.
        rd_en_cnt = 0;
        start_frame();
        send_byte(8'h82, mb0);
        send_byte(8'h00, mb1);
        send_byte(8'h00, mb2);
        end_frame(1'b1);
        check("rd_addr_byte_miso", 32'(mb0), 32'h00);
        check("rd_no_write", 32'(wr_addr), 32'h10);
`ifdef SPI_FRAME_READBACK_EN
        check("rd_miso_byte0", 32'(mb1), 32'h42);
        check("rd_miso_byte1", 32'(mb2), 32'h43);
        check("rd_en_count",   32'(rd_en_cnt), 32'd2);
        check("rd_addr_final", 32'(rd_addr), 32'h04);
`else
        check("rd_miso_byte0", 32'(mb1), 32'h00);
        check("rd_miso_byte1", 32'(mb2), 32'h00);
        check("rd_en_count",   32'(rd_en_cnt), 32'd0);
        check("rd_addr_final", 32'(rd_addr), 32'h00);
`endif

        // A write after the read frame still lands normally.
        exp_q.push_back({7'h33, 8'h96});
        start_frame();
        send_byte(8'h33, mb0);
        send_byte(8'h96, mb0);
        end_frame(1'b1);
        check("post_rd_wr_count", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
